// File: rtl/rom_responder.sv
// rom_responder: ROM-side bus responder for a 4-bit multiplexed bus.
//
// The initiator's two-phase clock (clk1/clk2) is oversampled on sysclk.
// Every falling edge of clk2 ends one subcycle. Eight subcycles form a
// machine cycle:
//   A1 A2 A3 M1 M2 X1 X2 X3
// sync marks X3 and keeps the subcycle tracker aligned to the initiator.
// The address nibbles are captured in A1 and A2. Chip selection happens
// in A3. While selected, the addressed byte is driven back on the bus:
// the high nibble (OPR) in M1 and the low nibble (OPA) in M2.
//
// Ports
//   sysclk    in   system clock; all state changes on its rising edge
//   reset_n   in   synchronous, active-low reset
//   clk1      in   phase-1 enable (accepted for compatibility, unused)
//   clk2      in   phase-2 enable; its falling edge is the subcycle tick
//   sync      in   machine-cycle sync, high during X3
//   cm_rom    in   ROM command line, only meaningful in A3
//   data_in   in   [3:0] bus nibble from the initiator
//   data_out  out  [3:0] nibble driven onto the bus, 0 when not driving
//   data_oe   out  bus drive enable
//   rom_addr  out  [7:0] byte address to the ROM array
//   rom_data  in   [7:0] array read data, valid one sysclk after rom_addr
//   locked    out  subcycle tracker is aligned to sync
//   sync_err  out  one-sysclk pulse on a misplaced or missing sync
module rom_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } subcycle_t;

  subcycle_t  counter_reg;
  logic       clk2_reg;
  logic       locked_reg;
  logic       selected_reg;
  logic       sync_err_reg;
  logic       data_oe_reg;
  logic [3:0] data_out_reg;
  logic [3:0] addr_lo_reg;
  logic [7:0] rom_addr_reg;    // [7:4] is the A2 nibble, [3:0] the A1 nibble
  logic       cap_pending_reg; // set for one sysclk after the A3 tick
  logic [7:0] word_reg;        // OPR/OPA byte for the current cycle

  logic       tick;
  logic       in_mem_phase;
  logic       drive_next;
  logic [7:0] word_next;
  logic       unused_inputs;

  // clk1 carries no information that clk2 does not already supply.
  assign unused_inputs = clk1;

  assign tick         = clk2_reg & ~clk2;
  assign in_mem_phase = (counter_reg == M1) || (counter_reg == M2);

  // A sync arriving on this tick restarts the cycle. That sync cuts off
  // the drive on the same edge instead of one sysclk later.
  assign drive_next = selected_reg & in_mem_phase & ~(tick & sync);

  // The byte is captured on the same edge that first drives it. Bypass
  // the capture register so M1 starts with the fresh byte.
  assign word_next = cap_pending_reg ? rom_data : word_reg;

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      counter_reg     <= X3;
      clk2_reg        <= 1'b0;
      locked_reg      <= 1'b0;
      selected_reg    <= 1'b0;
      sync_err_reg    <= 1'b0;
      data_oe_reg     <= 1'b0;
      data_out_reg    <= 4'h0;
      addr_lo_reg     <= 4'h0;
      rom_addr_reg    <= 8'h00;
      cap_pending_reg <= 1'b0;
      word_reg        <= 8'h00;
    end else begin
      clk2_reg        <= clk2;
      sync_err_reg    <= 1'b0;
      cap_pending_reg <= 1'b0;
      if (cap_pending_reg) begin
        word_reg <= rom_data;
      end

      data_oe_reg <= drive_next;
      if (drive_next) begin
        data_out_reg <= (counter_reg == M1) ? word_next[7:4] : word_next[3:0];
      end else begin
        data_out_reg <= 4'h0;
      end

      if (tick) begin
        // Address capture follows the subcycle that is ending.
        if (counter_reg == A1) begin
          addr_lo_reg <= data_in;
        end
        if (counter_reg == A2) begin
          rom_addr_reg <= {data_in, addr_lo_reg};
        end

        if (sync) begin
          // A sync anywhere except the end of X3 means the tracker was
          // misaligned. Report the error only if lock was already held.
          counter_reg  <= A1;
          locked_reg   <= 1'b1;
          selected_reg <= 1'b0;
          if ((counter_reg != X3) && locked_reg) begin
            sync_err_reg <= 1'b1;
          end
        end else begin
          counter_reg <= subcycle_t'(counter_reg + 3'd1);
          if (counter_reg == A3) begin
            selected_reg    <= locked_reg & cm_rom & (data_in == CHIP_ID);
            cap_pending_reg <= 1'b1;
          end
          if (counter_reg == X3) begin
            // X3 ended without sync, so the tracker has lost alignment.
            locked_reg   <= 1'b0;
            selected_reg <= 1'b0;
            sync_err_reg <= locked_reg;
          end
        end
      end
    end
  end

  assign data_out = data_out_reg;
  assign data_oe  = data_oe_reg;
  assign rom_addr = rom_addr_reg;
  assign locked   = locked_reg;
  assign sync_err = sync_err_reg;

endmodule
